pll_rst_sequencer: RTL and testbench

- Parametrised supervisor for a Gowin rPLL instance; clocked by the free-running PLL reference clock (40 MHz board clock).
- Drives PLL reset, qualifies the asynchronous lock signal, and retries on lock timeout.
- Releases NUM_CH downstream resets in staggered order; tears everything down on lock loss.
- Downstream domains re-synchronise their ch_rst_n bit locally.

---
 rtl/pll_rst_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pll_rst_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pll_rst_sequencer.sv
// Supervisor for a Gowin rPLL: drives PLL reset, qualifies lock, retries on timeout,
// then releases NUM_CH downstream resets in staggered order and tears down on lock loss.
module pll_rst_sequencer #(
  parameter int NUM_CH       = 3,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_TIMEOUT = 4000,
  parameter int LOCK_STABLE  = 64,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRY    = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_lock,
  input  logic              sw_restart,
  output logic              pll_rst,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              ready,
  output logic              fail,
  output logic [3:0]        retry_cnt,
  output logic [7:0]        lost_cnt
);

  localparam int REL_LAST = (NUM_CH - 1) * STAGGER;
  localparam int MAX_AB   = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
  localparam int MAX_CD   = (LOCK_STABLE > REL_LAST) ? LOCK_STABLE : REL_LAST;
  localparam int CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               lock_meta_r;
  logic               lock_sync_r;
  logic               pll_rst_r;
  logic [NUM_CH-1:0]  ch_rst_n_r;
  logic               ready_r;
  logic               fail_r;
  logic [3:0]         retry_cnt_r;
  logic [7:0]         lost_cnt_r;

  // Two-flop synchroniser bringing the asynchronous rPLL lock into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_lock;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Sequencer state machine with registered outputs; sw_restart overrides every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_RST_PLL;
      cnt_r       <= '0;
      pll_rst_r   <= 1'b1;
      ch_rst_n_r  <= '0;
      ready_r     <= 1'b0;
      fail_r      <= 1'b0;
      retry_cnt_r <= 4'd0;
      lost_cnt_r  <= 8'd0;
    end else if (sw_restart) begin
      state_r     <= ST_RST_PLL;
      cnt_r       <= '0;
      pll_rst_r   <= 1'b1;
      ch_rst_n_r  <= '0;
      ready_r     <= 1'b0;
      fail_r      <= 1'b0;
      retry_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_RST_PLL: begin
          pll_rst_r  <= 1'b1;
          ch_rst_n_r <= '0;
          ready_r    <= 1'b0;
          if (cnt_r == CNT_W'(PLL_RST_CYC - 1)) begin
            state_r   <= ST_WAIT_LOCK;
            cnt_r     <= '0;
            pll_rst_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_sync_r) begin
            state_r <= ST_STABLE;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
            cnt_r     <= '0;
            pll_rst_r <= 1'b1;
            if ((MAX_RETRY != 0) && (retry_cnt_r == RETRY_LIMIT)) begin
              state_r <= ST_FAIL;
              fail_r  <= 1'b1;
            end else begin
              state_r <= ST_RST_PLL;
              if (retry_cnt_r != 4'hF) begin
                retry_cnt_r <= retry_cnt_r + 4'd1;
              end
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_STABLE: begin
          if (!lock_sync_r) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_W'(LOCK_STABLE - 1)) begin
            state_r <= ST_RELEASE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (!lock_sync_r) begin
            state_r    <= ST_RST_PLL;
            cnt_r      <= '0;
            pll_rst_r  <= 1'b1;
            ch_rst_n_r <= '0;
            ready_r    <= 1'b0;
            if (lost_cnt_r != 8'hFF) begin
              lost_cnt_r <= lost_cnt_r + 8'd1;
            end
          end else begin
            // Bits only ever get set here, so release order follows the counter.
            for (int i = 0; i < NUM_CH; i++) begin
              if (cnt_r == CNT_W'(i * STAGGER)) begin
                ch_rst_n_r[i] <= 1'b1;
              end
            end
            if (cnt_r == CNT_W'(REL_LAST)) begin
              state_r     <= ST_RUN;
              cnt_r       <= '0;
              ready_r     <= 1'b1;
              retry_cnt_r <= 4'd0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end

        ST_RUN: begin
          if (!lock_sync_r) begin
            state_r    <= ST_RST_PLL;
            cnt_r      <= '0;
            pll_rst_r  <= 1'b1;
            ch_rst_n_r <= '0;
            ready_r    <= 1'b0;
            if (lost_cnt_r != 8'hFF) begin
              lost_cnt_r <= lost_cnt_r + 8'd1;
            end
          end else begin
            cnt_r <= '0;
          end
        end

        ST_FAIL: begin
          pll_rst_r  <= 1'b1;
          ch_rst_n_r <= '0;
          ready_r    <= 1'b0;
          fail_r     <= 1'b1;
          cnt_r      <= '0;
        end

        default: begin
          state_r    <= ST_RST_PLL;
          cnt_r      <= '0;
          pll_rst_r  <= 1'b1;
          ch_rst_n_r <= '0;
          ready_r    <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = pll_rst_r;
  assign ch_rst_n  = ch_rst_n_r;
  assign ready     = ready_r;
  assign fail      = fail_r;
  assign retry_cnt = retry_cnt_r;
  assign lost_cnt  = lost_cnt_r;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Directed bench for pll_rst_sequencer: expected output snapshots are queued as each
// step is driven and popped against the DUT at the sample point after the clock edge.
module tb_pll_rst_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       sw_restart;
  logic       pll_rst;
  logic [2:0] ch_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string       tag;
    logic [17:0] snap;
  } exp_t;

  exp_t exp_q[$];

  pll_rst_sequencer #(
    .NUM_CH(3), .PLL_RST_CYC(4), .LOCK_TIMEOUT(20),
    .LOCK_STABLE(8), .STAGGER(8), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .sw_restart(sw_restart),
    .pll_rst(pll_rst), .ch_rst_n(ch_rst_n), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle to a sample point away from the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input string tag, input logic p, input logic [2:0] ch,
                          input logic rdy, input logic f, input logic [3:0] rc,
                          input logic [7:0] lc);
    exp_t e;
    e.tag  = tag;
    e.snap = {p, ch, rdy, f, rc, lc};
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [17:0] obs;
    e   = exp_q.pop_front();
    obs = {pll_rst, ch_rst_n, ready, fail, retry_cnt, lost_cnt};
    checks++;
    assert (obs === e.snap) passes++;
    else $error("FAIL %s: observed pll_rst=%b ch=%b rdy=%b fail=%b retry=%0d lost=%0d expected pll_rst=%b ch=%b rdy=%b fail=%b retry=%0d lost=%0d",
                e.tag, obs[17], obs[16:14], obs[13], obs[12], obs[11:8], obs[7:0],
                e.snap[17], e.snap[16:14], e.snap[13], e.snap[12], e.snap[11:8], e.snap[7:0]);
  endtask

  task automatic chk(input string tag, input logic p, input logic [2:0] ch,
                     input logic rdy, input logic f, input logic [3:0] rc,
                     input logic [7:0] lc);
    push_exp(tag, p, ch, rdy, f, rc, lc);
    pop_check();
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_lock   = 1'b0;
    sw_restart = 1'b0;
    cyc(2);
    chk("reset_state", 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0);

    // Nominal lock: reset released, lock raised 10 cycles later.
    reset_n = 1'b1;
    cyc(3);  chk("pll_rst_held",   1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(1);  chk("pll_rst_drop",   1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(6);  pll_lock = 1'b1;
    cyc(11); chk("release_entry",  1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(1);  chk("ch_001",         1'b0, 3'b001, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(7);  chk("ch_001_hold",    1'b0, 3'b001, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(1);  chk("ch_011",         1'b0, 3'b011, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(7);  chk("ch_011_hold",    1'b0, 3'b011, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(1);  chk("ch_111_ready",   1'b0, 3'b111, 1'b1, 1'b0, 4'd0, 8'd0);

    // Lock loss in RUN: two sync cycles, then full teardown on one edge.
    pll_lock = 1'b0;
    cyc(2);  chk("run_loss_sync",  1'b0, 3'b111, 1'b1, 1'b0, 4'd0, 8'd0);
    cyc(1);  chk("run_loss_down",  1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd1);
    pll_lock = 1'b1;
    cyc(4);  chk("relock_rst_end", 1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd1);
    cyc(18); chk("mid_release",    1'b0, 3'b011, 1'b0, 1'b0, 4'd0, 8'd1);
    pll_lock = 1'b0;
    cyc(2);  chk("rel_loss_sync",  1'b0, 3'b011, 1'b0, 1'b0, 4'd0, 8'd1);
    cyc(1);  chk("rel_loss_down",  1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);

    // Glitch during STABLE: 5 high, 1 low, then high.
    cyc(4);  chk("glitch_rst_end", 1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);
    pll_lock = 1'b1;
    cyc(5);  pll_lock = 1'b0;
    cyc(1);  pll_lock = 1'b1;
    cyc(6);  chk("glitch_no_rel",  1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);
    cyc(5);  chk("glitch_pre_rel", 1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);
    cyc(1);  chk("glitch_ch_001",  1'b0, 3'b001, 1'b0, 1'b0, 4'd0, 8'd2);
    cyc(16); chk("glitch_ready",   1'b0, 3'b111, 1'b1, 1'b0, 4'd0, 8'd2);

    // Two timeouts then success; restart from RUN does not count as lock loss.
    pll_lock = 1'b0;
    sw_restart = 1'b1;
    cyc(1);  sw_restart = 1'b0;
    chk("restart_run",    1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);
    cyc(4);  chk("retry_wait0",    1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);
    cyc(19); chk("pre_timeout1",   1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);
    cyc(1);  chk("timeout1",       1'b1, 3'b000, 1'b0, 1'b0, 4'd1, 8'd2);
    cyc(4);  chk("retry_wait1",    1'b0, 3'b000, 1'b0, 1'b0, 4'd1, 8'd2);
    cyc(19); chk("pre_timeout2",   1'b0, 3'b000, 1'b0, 1'b0, 4'd1, 8'd2);
    cyc(1);  chk("timeout2",       1'b1, 3'b000, 1'b0, 1'b0, 4'd2, 8'd2);
    cyc(4);  chk("retry_wait2",    1'b0, 3'b000, 1'b0, 1'b0, 4'd2, 8'd2);
    pll_lock = 1'b1;
    cyc(27); chk("retry_pre_rdy",  1'b0, 3'b011, 1'b0, 1'b0, 4'd2, 8'd2);
    cyc(1);  chk("retry_cleared",  1'b0, 3'b111, 1'b1, 1'b0, 4'd0, 8'd2);

    // Retry exhaustion into FAIL, then recovery by sw_restart.
    pll_lock = 1'b0;
    sw_restart = 1'b1;
    cyc(1);  sw_restart = 1'b0;
    cyc(71); chk("pre_fail",       1'b0, 3'b000, 1'b0, 1'b0, 4'd2, 8'd2);
    cyc(1);  chk("fail_entry",     1'b1, 3'b000, 1'b0, 1'b1, 4'd2, 8'd2);
    cyc(5);  chk("fail_sticky",    1'b1, 3'b000, 1'b0, 1'b1, 4'd2, 8'd2);
    sw_restart = 1'b1;
    cyc(1);  sw_restart = 1'b0;
    chk("fail_restart",   1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);
    cyc(3);  chk("restart_hold",   1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);
    cyc(1);  chk("restart_drop",   1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);

    // sw_restart coinciding with a timeout: retry_cnt must clear, not increment.
    cyc(20); chk("prio_timeout1",  1'b1, 3'b000, 1'b0, 1'b0, 4'd1, 8'd2);
    cyc(4);  chk("prio_wait",      1'b0, 3'b000, 1'b0, 1'b0, 4'd1, 8'd2);
    cyc(19); sw_restart = 1'b1;
    cyc(1);  sw_restart = 1'b0;
    chk("prio_restart",   1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);
    cyc(4);  chk("prio_rst_end",   1'b0, 3'b000, 1'b0, 1'b0, 4'd0, 8'd2);

    // Asynchronous reset mid-RELEASE, asserted between clock edges.
    pll_lock = 1'b1;
    cyc(21); chk("async_pre",      1'b0, 3'b011, 1'b0, 1'b0, 4'd0, 8'd2);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset",    1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(2);
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
